// File: rtl/cfg_arb_pkg.sv
// ---------------------------------------------------------------------------
// cfg_arb_pkg
// Shared types and constants for the config write-path arbiter.
//   arbState_e   : arbiter state (IDLE, SWITCH, OWN)
//   DROP_CNT_W   : width of the saturating dropped-word counter
//   REPLAY_DEPTH : number of words the replay FIFO can hold
//   satAdd()     : saturating add used by the drop counter
// ---------------------------------------------------------------------------
package cfg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    OWN    = 2'd2
  } arbState_e;

  localparam int DROP_CNT_W   = 16;
  localparam int REPLAY_DEPTH = 2;
  localparam int REPLAY_CNT_W = $clog2(REPLAY_DEPTH + 1);

  // Adds inc to base and clamps at the all-ones value instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] satAdd(input logic [DROP_CNT_W-1:0] base,
                                                   input logic [DROP_CNT_W-1:0] inc);
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/cfg_replay_fifo.sv
// ---------------------------------------------------------------------------
// cfg_replay_fifo
// Small replay FIFO that holds the words accepted around an ownership change
// until the config write path is free to emit them.
// Ports:
//   CLK, reset  : clock, synchronous active-high reset
//   push        : write pushData (accepted when not full, or when a pop frees a slot)
//   pop         : remove the head entry (ignored when empty)
//   flush       : discard all entries; a push in the same cycle lands in the empty FIFO
//   headData    : current head entry (valid when !empty)
//   full, empty : occupancy flags
//   count       : number of stored entries
// ---------------------------------------------------------------------------
module cfg_replay_fifo
  import cfg_arb_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DataWidth-1:0]    pushData,
  input  logic                    pop,
  input  logic                    flush,
  output logic [DataWidth-1:0]    headData,
  output logic                    full,
  output logic                    empty,
  output logic [REPLAY_CNT_W-1:0] count
);

  localparam int PtrW = $clog2(REPLAY_DEPTH);

  logic [DataWidth-1:0] mem [REPLAY_DEPTH];
  logic [PtrW-1:0]      rdPtr;
  logic [PtrW-1:0]      wrPtr;
  logic [PtrW-1:0]      memAddr;
  logic                 doPop;
  logic                 doPush;

  assign empty    = (count == '0);
  assign full     = (count == REPLAY_CNT_W'(REPLAY_DEPTH));
  assign doPop    = pop && !empty && !flush;
  assign doPush   = push && (flush || !full || doPop);
  assign memAddr  = flush ? '0 : wrPtr;
  assign headData = mem[rdPtr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= doPush ? PtrW'(1) : '0;
      count <= doPush ? REPLAY_CNT_W'(1) : '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + REPLAY_CNT_W'(doPush) - REPLAY_CNT_W'(doPop);
    end
  end

  // NOTE: the storage array has no reset; count and pointers alone decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (doPush) mem[memAddr] <= pushData;
  end

endmodule

// File: rtl/config_port_arbiter.sv
// ---------------------------------------------------------------------------
// config_port_arbiter
// Shares the single config write path into ConfigFSM between NumPorts sources
// (0 = UART, 1 = bitbang, 2 = CPU self-write; lower index = higher priority).
// A source takes ownership by asserting its active flag or strobing; the owner
// keeps the path until it goes quiet for IdleTimeout cycles or a higher-priority
// source becomes active. Words strobed during the hand-over are captured in a
// replay FIFO and emitted in order once ownership is settled.
// Ports:
//   CLK, reset        : clock, synchronous active-high reset
//   req_active        : per-source session flag
//   req_strobe        : per-source one-cycle write strobe
//   req_data          : per-source word, source i at [i*DataWidth +: DataWidth]
//   ConfigWriteData   : registered word to ConfigFSM (holds when idle)
//   ConfigWriteStrobe : registered one-cycle write strobe to ConfigFSM
//   FSM_Reset         : one-cycle pulse on every ownership change
//   Owner, OwnerValid : current owner index and its valid flag
//   DropCount         : saturating count of discarded words
// ---------------------------------------------------------------------------
module config_port_arbiter
  import cfg_arb_pkg::*;
#(
  parameter  int NumPorts    = 3,
  parameter  int DataWidth   = 32,
  parameter  int IdleTimeout = 1024,
  localparam int OwnerWidth  = $clog2(NumPorts)
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic [NumPorts-1:0]             req_active,
  input  logic [NumPorts-1:0]             req_strobe,
  input  logic [NumPorts*DataWidth-1:0]   req_data,
  output logic [DataWidth-1:0]            ConfigWriteData,
  output logic                            ConfigWriteStrobe,
  output logic                            FSM_Reset,
  output logic [OwnerWidth-1:0]           Owner,
  output logic                            OwnerValid,
  output logic [DROP_CNT_W-1:0]           DropCount
);

  localparam int                  IdleCntW = $clog2(IdleTimeout);
  localparam logic [IdleCntW-1:0] IdleLast = IdleCntW'(IdleTimeout - 1);

  arbState_e              state;
  arbState_e              nextState;
  logic [DataWidth-1:0]   portData [NumPorts];
  logic [DataWidth-1:0]   ownerData;
  logic                   ownerStrobe;
  logic                   ownerActive;
  logic [IdleCntW-1:0]    idleCnt;
  logic [IdleCntW-1:0]    idleCntNext;
  logic [OwnerWidth-1:0]  newOwner;
  logic                   idleWinValid;
  logic [OwnerWidth-1:0]  idleWin;
  logic                   preemptValid;
  logic [OwnerWidth-1:0]  preemptWin;
  logic [NumPorts-1:0]    acceptMask;
  logic                   forward;
  logic [DROP_CNT_W-1:0]  dropInc;

  logic                    fifoPush;
  logic                    fifoPop;
  logic                    fifoFlush;
  logic                    fifoFull;
  logic                    fifoEmpty;
  logic                    fifoOverflow;
  logic [DataWidth-1:0]    fifoPushData;
  logic [DataWidth-1:0]    fifoHead;
  logic [REPLAY_CNT_W-1:0] fifoCount;

  for (genvar g = 0; g < NumPorts; g++) begin : gUnpack
    assign portData[g] = req_data[g*DataWidth +: DataWidth];
  end

  assign ownerData   = portData[Owner];
  assign ownerStrobe = req_strobe[Owner];
  assign ownerActive = req_active[Owner];

  // Priority encoders: scanning from the top down lets the lowest index win.
  // NOTE: combinational blocks assign every output a default first and use
  // blocking assignments, so no path leaves a signal unassigned (no latch).
  always_comb begin
    idleWinValid = 1'b0;
    idleWin      = '0;
    preemptValid = 1'b0;
    preemptWin   = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (req_active[i] || req_strobe[i]) begin
        idleWinValid = 1'b1;
        idleWin      = OwnerWidth'(i);
      end
      if (req_active[i] && (i < int'(Owner))) begin
        preemptValid = 1'b1;
        preemptWin   = OwnerWidth'(i);
      end
    end
  end

  // Next-state, FIFO control and word acceptance. acceptMask marks the one
  // source whose strobe is taken this cycle; every other strobe is a drop.
  always_comb begin
    nextState    = state;
    newOwner     = Owner;
    idleCntNext  = idleCnt;
    fifoPush     = 1'b0;
    fifoPop      = 1'b0;
    fifoFlush    = 1'b0;
    fifoPushData = ownerData;
    acceptMask   = '0;
    forward      = 1'b0;
    unique case (state)
      IDLE: begin
        if (idleWinValid) begin
          nextState = SWITCH;
          newOwner  = idleWin;
          if (req_strobe[idleWin]) begin
            fifoPush            = 1'b1;
            fifoPushData        = portData[idleWin];
            acceptMask[idleWin] = 1'b1;
          end
        end
      end
      SWITCH: begin
        nextState = OWN;
        if (ownerStrobe) begin
          fifoPush          = 1'b1;
          acceptMask[Owner] = 1'b1;
        end
      end
      OWN: begin
        if (preemptValid) begin
          nextState = SWITCH;
          newOwner  = preemptWin;
          fifoFlush = 1'b1;
          if (req_strobe[preemptWin]) begin
            fifoPush               = 1'b1;
            fifoPushData           = portData[preemptWin];
            acceptMask[preemptWin] = 1'b1;
          end
        end else begin
          // Backlog drains first; a live strobe queues behind it so the
          // owner's write order is preserved.
          fifoPop = !fifoEmpty;
          if (ownerStrobe) begin
            acceptMask[Owner] = 1'b1;
            if (fifoEmpty) forward  = 1'b1;
            else           fifoPush = 1'b1;
          end
          if (ownerActive || ownerStrobe) idleCntNext = '0;
          else if (!fifoEmpty)            idleCntNext = idleCnt;
          else if (idleCnt == IdleLast)   nextState   = IDLE;
          else                            idleCntNext = idleCnt + 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
    if (nextState == SWITCH) idleCntNext = '0;
  end

  assign fifoOverflow = fifoPush && fifoFull && !fifoPop && !fifoFlush;

  always_comb begin
    dropInc = '0;
    for (int i = 0; i < NumPorts; i++) begin
      dropInc = dropInc + DROP_CNT_W'(req_strobe[i] && !acceptMask[i]);
    end
    dropInc = dropInc + DROP_CNT_W'(fifoOverflow);
    if (fifoFlush) dropInc = dropInc + DROP_CNT_W'(fifoCount);
  end

  cfg_replay_fifo #(
    .DataWidth (DataWidth)
  ) uReplayFifo (
    .CLK      (CLK),
    .reset    (reset),
    .push     (fifoPush),
    .pushData (fifoPushData),
    .pop      (fifoPop),
    .flush    (fifoFlush),
    .headData (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state             <= IDLE;
      Owner             <= '0;
      OwnerValid        <= 1'b0;
      FSM_Reset         <= 1'b0;
      ConfigWriteStrobe <= 1'b0;
      ConfigWriteData   <= '0;
      DropCount         <= '0;
      idleCnt           <= '0;
    end else begin
      state             <= nextState;
      Owner             <= newOwner;
      OwnerValid        <= (nextState != IDLE);
      FSM_Reset         <= (nextState == SWITCH);
      idleCnt           <= idleCntNext;
      DropCount         <= satAdd(DropCount, dropInc);
      ConfigWriteStrobe <= fifoPop || forward;
      if (fifoPop)      ConfigWriteData <= fifoHead;
      else if (forward) ConfigWriteData <= ownerData;
    end
  end

endmodule

// File: tb/tb_config_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_config_port_arbiter
// Drives config_port_arbiter (IdleTimeout = 4) with directed hand-over
// sequences followed by randomized traffic. A queue-based reference model
// predicts every emitted word, every ownership change and the per-cycle
// status; a monitor process compares the DUT against those predictions.
// ---------------------------------------------------------------------------
module tb_config_port_arbiter;

  localparam int NP = 3;
  localparam int DW = 32;
  localparam int TO = 4;

  logic              CLK = 1'b0;
  logic              reset;
  logic [NP-1:0]     req_active;
  logic [NP-1:0]     req_strobe;
  logic [NP*DW-1:0]  req_data;
  logic [DW-1:0]     ConfigWriteData;
  logic              ConfigWriteStrobe;
  logic              FSM_Reset;
  logic [1:0]        Owner;
  logic              OwnerValid;
  logic [15:0]       DropCount;

  always #5 CLK = ~CLK;

  config_port_arbiter #(
    .NumPorts    (NP),
    .DataWidth   (DW),
    .IdleTimeout (TO)
  ) dut (
    .CLK               (CLK),
    .reset             (reset),
    .req_active        (req_active),
    .req_strobe        (req_strobe),
    .req_data          (req_data),
    .ConfigWriteData   (ConfigWriteData),
    .ConfigWriteStrobe (ConfigWriteStrobe),
    .FSM_Reset         (FSM_Reset),
    .Owner             (Owner),
    .OwnerValid        (OwnerValid),
    .DropCount         (DropCount)
  );

  typedef struct { int edgeIdx; logic [31:0] data; } wrExp_t;
  typedef struct { int edgeIdx; int owner; } swExp_t;
  typedef struct { int edgeIdx; int drops; bit ownerValid; logic [31:0] data; int owner; } status_t;

  wrExp_t  writeQ[$];
  swExp_t  switchQ[$];
  status_t statusQ[$];

  int checks = 0;
  int errors = 0;
  int edgeNo = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, actual, expected, edgeNo);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mOwned;
  bit          mSwitching;
  int          mOwner;
  int          mQuiet;
  int          mDrops;
  logic [31:0] mLast;
  logic [31:0] mPending[$];

  function automatic int lowest(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int strobesExcept(input int keep);
    int n = 0;
    for (int i = 0; i < NP; i++) if (req_strobe[i] && i != keep) n++;
    return n;
  endfunction

  function automatic logic [31:0] dat(input int i);
    return req_data[i*DW +: DW];
  endfunction

  task automatic addDrops(input int n);
    mDrops = (mDrops + n > 65535) ? 65535 : mDrops + n;
  endtask

  task automatic queueWord(input logic [31:0] w);
    if (mPending.size() < 2) mPending.push_back(w);
    else addDrops(1);
  endtask

  task automatic emit(input int up, input logic [31:0] w);
    writeQ.push_back('{up, w});
    mLast = w;
  endtask

  // Predicts the effect of the upcoming clock edge given the driven inputs.
  task automatic modelStep();
    int up = edgeNo + 1;
    int w;
    int backlog;
    logic [NP-1:0] higher;
    if (reset) begin
      mOwned = 0; mSwitching = 0; mOwner = 0; mQuiet = 0; mDrops = 0; mLast = '0;
      mPending.delete();
    end else if (!mOwned) begin
      w = lowest(req_active | req_strobe);
      if (w >= 0) begin
        addDrops(strobesExcept(w));
        mOwned = 1; mSwitching = 1; mOwner = w; mQuiet = 0;
        if (req_strobe[w]) queueWord(dat(w));
        switchQ.push_back('{up, w});
      end
    end else if (mSwitching) begin
      mSwitching = 0;
      addDrops(strobesExcept(mOwner));
      if (req_strobe[mOwner]) queueWord(dat(mOwner));
    end else begin
      higher = NP'((1 << mOwner) - 1);
      w = lowest(req_active & higher);
      if (w >= 0) begin
        addDrops(mPending.size());
        mPending.delete();
        addDrops(strobesExcept(w));
        mOwner = w; mSwitching = 1; mQuiet = 0;
        if (req_strobe[w]) queueWord(dat(w));
        switchQ.push_back('{up, w});
      end else begin
        backlog = mPending.size();
        addDrops(strobesExcept(mOwner));
        if (backlog > 0) begin
          emit(up, mPending.pop_front());
          if (req_strobe[mOwner]) queueWord(dat(mOwner));
        end else if (req_strobe[mOwner]) begin
          emit(up, dat(mOwner));
        end
        if (req_active[mOwner] || req_strobe[mOwner]) mQuiet = 0;
        else if (backlog == 0) begin
          if (mQuiet == TO - 1) mOwned = 0;
          else mQuiet++;
        end
      end
    end
    statusQ.push_back('{up, mDrops, mOwned, mLast, mOwner});
  endtask

  // ---------------- monitor ----------------
  always @(posedge CLK) begin : monitor
    status_t s;
    bit expSw;
    bit expWr;
    edgeNo++;
    #1;
    if (statusQ.size() > 0) begin
      s = statusQ.pop_front();
      check("drop_count", DropCount, s.drops);
      check("owner_valid", OwnerValid, s.ownerValid);
      check("write_data_hold", ConfigWriteData, s.data);
      if (s.ownerValid) check("owner", Owner, s.owner);
    end
    expSw = (switchQ.size() > 0) && (switchQ[0].edgeIdx == edgeNo);
    check("fsm_reset", FSM_Reset, expSw);
    if (expSw) void'(switchQ.pop_front());
    expWr = (writeQ.size() > 0) && (writeQ[0].edgeIdx == edgeNo);
    check("write_strobe", ConfigWriteStrobe, expWr);
    if (expWr) begin
      check("write_word", ConfigWriteData, writeQ[0].data);
      void'(writeQ.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input bit rst, input logic [NP-1:0] act, input logic [NP-1:0] stb,
                       input logic [NP*DW-1:0] d);
    reset      = rst;
    req_active = act;
    req_strobe = stb;
    req_data   = d;
    modelStep();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [NP*DW-1:0] pack(input logic [31:0] d0, input logic [31:0] d1,
                                             input logic [31:0] d2);
    return {d2, d1, d0};
  endfunction

  initial begin
    logic [NP-1:0] sess;
    logic [NP-1:0] stb;
    int quietLeft;

    cycle(1, '0, '0, '0);
    cycle(1, '0, '0, '0);

    // Port 2 takes the idle path: SWITCH pulse, word emitted two cycles later.
    cycle(0, 3'b100, 3'b100, pack(32'h0, 32'h0, 32'hA5A5_0001));
    check("t2_fsm_reset", FSM_Reset, 1'b1);
    check("t2_owner", Owner, 2'd2);
    check("t2_no_strobe_switch", ConfigWriteStrobe, 1'b0);
    cycle(0, 3'b100, 3'b000, '0);
    check("t2_fsm_reset_1cyc", FSM_Reset, 1'b0);
    check("t2_no_strobe_early", ConfigWriteStrobe, 1'b0);
    cycle(0, 3'b100, 3'b000, '0);
    check("t2_strobe", ConfigWriteStrobe, 1'b1);
    check("t2_data", ConfigWriteData, 32'hA5A5_0001);

    // Non-owner port 1 strobes while port 2 owns: dropped.
    cycle(0, 3'b100, 3'b010, pack(32'h0, 32'h1, 32'h0));
    check("t3_drop", DropCount, 16'd1);
    check("t3_no_strobe", ConfigWriteStrobe, 1'b0);
    cycle(0, 3'b100, 3'b000, '0);
    check("t3_no_strobe_late", ConfigWriteStrobe, 1'b0);

    // Reset held three cycles while owned.
    cycle(1, 3'b100, 3'b100, pack(32'h0, 32'h0, 32'hDEAD_0001));
    cycle(1, 3'b100, 3'b100, pack(32'h0, 32'h0, 32'hDEAD_0002));
    cycle(1, 3'b100, 3'b100, pack(32'h0, 32'h0, 32'hDEAD_0003));
    check("t1_strobe", ConfigWriteStrobe, 1'b0);
    check("t1_fsm_reset", FSM_Reset, 1'b0);
    check("t1_owner_valid", OwnerValid, 1'b0);
    check("t1_owner", Owner, 2'd0);
    check("t1_drop", DropCount, 16'd0);
    check("t1_data", ConfigWriteData, 32'h0);

    // Re-arbitration from IDLE, two port-2 words queued, then port 0 preempts.
    cycle(0, 3'b100, 3'b100, pack(32'h0, 32'h0, 32'h2222_0001));
    check("t1_rearb_pulse", FSM_Reset, 1'b1);
    check("t1_rearb_owner", Owner, 2'd2);
    cycle(0, 3'b100, 3'b100, pack(32'h0, 32'h0, 32'h2222_0002));
    cycle(0, 3'b101, 3'b001, pack(32'h0000_BEEF, 32'h0, 32'h0));
    check("t4_fsm_reset", FSM_Reset, 1'b1);
    check("t4_owner", Owner, 2'd0);
    check("t4_flush_drops", DropCount, 16'd2);
    check("t4_no_strobe", ConfigWriteStrobe, 1'b0);
    cycle(0, 3'b001, 3'b000, '0);
    check("t4_pulse_end", FSM_Reset, 1'b0);
    cycle(0, 3'b000, 3'b000, '0);
    check("t4_beef_strobe", ConfigWriteStrobe, 1'b1);
    check("t4_beef_data", ConfigWriteData, 32'h0000_BEEF);

    // Owner quiet: released after the fourth quiet cycle.
    cycle(0, '0, '0, '0);
    cycle(0, '0, '0, '0);
    cycle(0, '0, '0, '0);
    check("t5_still_owned", OwnerValid, 1'b1);
    cycle(0, '0, '0, '0);
    check("t5_released", OwnerValid, 1'b0);
    cycle(0, 3'b000, 3'b010, pack(32'h0, 32'h1111_0001, 32'h0));
    check("t5_new_owner", Owner, 2'd1);
    check("t5_pulse", FSM_Reset, 1'b1);
    cycle(0, '0, '0, '0);
    cycle(0, '0, '0, '0);
    check("t5_write", ConfigWriteData, 32'h1111_0001);

    // Strobes in IDLE, SWITCH and first OWN cycle emerge back-to-back.
    cycle(1, '0, '0, '0);
    cycle(0, 3'b010, 3'b010, pack(32'h0, 32'h6666_0000, 32'h0));
    cycle(0, 3'b010, 3'b010, pack(32'h0, 32'h6666_0001, 32'h0));
    cycle(0, 3'b010, 3'b010, pack(32'h0, 32'h6666_0002, 32'h0));
    check("t6_w0", ConfigWriteData, 32'h6666_0000);
    cycle(0, 3'b010, 3'b000, '0);
    check("t6_w1_strobe", ConfigWriteStrobe, 1'b1);
    check("t6_w1", ConfigWriteData, 32'h6666_0001);
    cycle(0, 3'b010, 3'b000, '0);
    check("t6_w2_strobe", ConfigWriteStrobe, 1'b1);
    check("t6_w2", ConfigWriteData, 32'h6666_0002);
    check("t6_no_drops", DropCount, 16'd0);

    // Randomized traffic with session-style active flags and quiet windows.
    sess = '0;
    quietLeft = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NP; p++) if ($urandom_range(0, 19) == 0) sess[p] = ~sess[p];
      for (int p = 0; p < NP; p++) stb[p] = ($urandom_range(0, 3) == 0);
      if (quietLeft == 0 && $urandom_range(0, 99) < 3) quietLeft = 8;
      if (quietLeft > 0) begin
        quietLeft--;
        cycle(0, '0, '0, pack($urandom, $urandom, $urandom));
      end else begin
        cycle($urandom_range(0, 299) == 0, sess, stb, pack($urandom, $urandom, $urandom));
      end
    end

    for (int n = 0; n < 10; n++) cycle(0, '0, '0, '0);
    check("write_queue_drained", writeQ.size(), 0);
    check("switch_queue_drained", switchQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
